// File: rtl/eth_rx_fcs_check.sv
// Ethernet receive FCS checker: strips the 4-byte FCS, checks CRC-32 and length, reports status.
// Define ETH_RX_STATS_EN to build the saturating frame counters; otherwise they read as zero.
module eth_rx_fcs_check #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        rx_clk,
    input  logic        rst_int_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_done,
    output logic [10:0] frame_len,
    output logic [3:0]  frame_status,
    output logic [31:0] rx_fcs,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_crc_err,
    output logic [15:0] cnt_len_err,
    output logic [15:0] cnt_runt
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [10:0] LEN_SAT     = 11'h7FF;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // Shift register: newest byte enters at dl_q[3]; dl_q[0] is the oldest once fill_q == 4.
    logic [7:0]  dl_q [4];
    logic [2:0]  fill_q;
    logic [31:0] crc_q;
    logic [10:0] len_q;
    logic        mac_err_q;

    logic        eof;
    logic [31:0] crc_next;
    logic [10:0] len_next;
    logic        mac_next;
    logic        crc_err;
    logic        len_err;
    logic        runt;
    logic [10:0] payload_len;

    always_comb begin
        eof         = s_axis_tvalid & s_axis_tlast;
        crc_next    = crc32_byte(crc_q, s_axis_tdata);
        len_next    = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
        mac_next    = mac_err_q | s_axis_tuser;
        crc_err     = (crc_next != CRC_RESIDUE);
        len_err     = (32'(len_next) < MIN_LEN) || (32'(len_next) > MAX_LEN);
        runt        = (len_next <= 11'd4);
        // A saturated total means the true length is unknown, so report the ceiling.
        payload_len = runt ? 11'd0 : ((len_next == LEN_SAT) ? LEN_SAT : len_next - 11'd4);
    end

    always_comb begin
        m_axis_tvalid = s_axis_tvalid && (fill_q == 3'd4);
        m_axis_tdata  = dl_q[0];
        m_axis_tlast  = m_axis_tvalid & s_axis_tlast;
        m_axis_tuser  = m_axis_tlast & (crc_err | len_err | mac_next);
    end

    always_ff @(posedge rx_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < 4; i++) dl_q[i] <= 8'd0;
            fill_q       <= 3'd0;
            crc_q        <= CRC_INIT;
            len_q        <= 11'd0;
            mac_err_q    <= 1'b0;
            frame_done   <= 1'b0;
            frame_len    <= 11'd0;
            frame_status <= 4'd0;
            rx_fcs       <= 32'd0;
        end else begin
            frame_done <= eof;
            if (eof) begin
                for (int i = 0; i < 4; i++) dl_q[i] <= 8'd0;
                fill_q       <= 3'd0;
                crc_q        <= CRC_INIT;
                len_q        <= 11'd0;
                mac_err_q    <= 1'b0;
                frame_len    <= payload_len;
                frame_status <= {runt, len_err, mac_next, crc_err};
                rx_fcs       <= {s_axis_tdata, dl_q[3], dl_q[2], dl_q[1]};
            end else if (s_axis_tvalid) begin
                dl_q[0]   <= dl_q[1];
                dl_q[1]   <= dl_q[2];
                dl_q[2]   <= dl_q[3];
                dl_q[3]   <= s_axis_tdata;
                fill_q    <= (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
                crc_q     <= crc_next;
                len_q     <= len_next;
                mac_err_q <= mac_next;
            end
        end
    end

`ifdef ETH_RX_STATS_EN
    logic [15:0] cnt_ok_q;
    logic [15:0] cnt_crc_q;
    logic [15:0] cnt_len_q;
    logic [15:0] cnt_runt_q;

    // One counter per frame; MAC errors are booked with CRC errors.
    always_ff @(posedge rx_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnt_ok_q   <= 16'd0;
            cnt_crc_q  <= 16'd0;
            cnt_len_q  <= 16'd0;
            cnt_runt_q <= 16'd0;
        end else if (eof) begin
            if (runt) begin
                if (cnt_runt_q != 16'hFFFF) cnt_runt_q <= cnt_runt_q + 16'd1;
            end else if (crc_err || mac_next) begin
                if (cnt_crc_q != 16'hFFFF) cnt_crc_q <= cnt_crc_q + 16'd1;
            end else if (len_err) begin
                if (cnt_len_q != 16'hFFFF) cnt_len_q <= cnt_len_q + 16'd1;
            end else begin
                if (cnt_ok_q != 16'hFFFF) cnt_ok_q <= cnt_ok_q + 16'd1;
            end
        end
    end

    assign cnt_ok      = cnt_ok_q;
    assign cnt_crc_err = cnt_crc_q;
    assign cnt_len_err = cnt_len_q;
    assign cnt_runt    = cnt_runt_q;
`else
    assign cnt_ok      = 16'd0;
    assign cnt_crc_err = 16'd0;
    assign cnt_len_err = 16'd0;
    assign cnt_runt    = 16'd0;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench for eth_rx_fcs_check: stimulus pushes expected beats/status, a monitor pops them.
module tb_eth_rx_fcs_check;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct packed {
        logic [10:0] len;
        logic [3:0]  st;
        logic [31:0] fcs;
        logic [15:0] ok;
        logic [15:0] crc;
        logic [15:0] lenc;
        logic [15:0] runt;
    } stat_t;

    logic        rx_clk = 1'b0;
    logic        rst_int_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        frame_done;
    logic [10:0] frame_len;
    logic [3:0]  frame_status;
    logic [31:0] rx_fcs;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_crc_err;
    logic [15:0] cnt_len_err;
    logic [15:0] cnt_runt;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t exp_q[$];
    stat_t stat_q[$];
    logic [7:0] fr [0:2047];
    int mc_ok = 0, mc_crc = 0, mc_len = 0, mc_runt = 0;
    int fr_id = 0;

    always #5 rx_clk = ~rx_clk;

    eth_rx_fcs_check #(
        .MIN_LEN(64),
        .MAX_LEN(1518)
    ) dut (
        .rx_clk       (rx_clk),
        .rst_int_n    (rst_int_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .frame_done   (frame_done),
        .frame_len    (frame_len),
        .frame_status (frame_status),
        .rx_fcs       (rx_fcs),
        .cnt_ok       (cnt_ok),
        .cnt_crc_err  (cnt_crc_err),
        .cnt_len_err  (cnt_len_err),
        .cnt_runt     (cnt_runt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial reflected CRC-32 step.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    function automatic logic [15:0] cexp(input int v);
`ifdef ETH_RX_STATS_EN
        return 16'(v);
`else
        return (v > 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic user);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        @(posedge rx_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // len: total bytes incl. FCS; flip: byte index to corrupt after FCS is appended;
    // mac_at: byte flagged with tuser; stop_at > 0 drives only that many bytes (no tlast).
    task automatic send_frame(input int len, input int flip, input int mac_at, input bit gaps,
                              input int stop_at);
        logic [31:0] c;
        logic [31:0] fcs;
        logic        crc_e, len_e, runt_e, mac_e, bad;
        beat_t       b;
        stat_t       s;
        int          n, idx;
        fr_id++;
        c = 32'hFFFF_FFFF;
        if (len > 4) begin
            for (int k = 0; k < len - 4; k++) begin
                fr[k] = 8'((k * 13 + fr_id * 29 + 1) & 255);
                c = crc_step(c, fr[k]);
            end
            fcs = ~c;
            for (int i = 0; i < 4; i++) fr[len - 4 + i] = fcs[8*i +: 8];
        end else begin
            for (int k = 0; k < len; k++) fr[k] = 8'((k * 13 + fr_id * 29 + 1) & 255);
        end
        if (flip >= 0) fr[flip] = fr[flip] ^ 8'h04;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < len; k++) c = crc_step(c, fr[k]);
        crc_e  = (c != 32'hDEBB_20E3);
        len_e  = (len < 64) || (len > 1518);
        runt_e = (len <= 4);
        mac_e  = (mac_at >= 0);
        bad    = crc_e | len_e | mac_e;
        n      = (stop_at > 0) ? stop_at : len;
        for (int k = 0; (k < len - 4) && (k + 4 < n); k++) begin
            b.d    = fr[k];
            b.last = (stop_at == 0) && (k == len - 5);
            b.user = b.last & bad;
            exp_q.push_back(b);
        end
        if (stop_at == 0) begin
            if (runt_e) mc_runt++;
            else if (crc_e || mac_e) mc_crc++;
            else if (len_e) mc_len++;
            else mc_ok++;
            s.len = runt_e ? 11'd0 : 11'(len - 4);
            s.st  = {runt_e, len_e, mac_e, crc_e};
            for (int i = 0; i < 4; i++) begin
                idx = len - 4 + i;
                s.fcs[8*i +: 8] = (idx >= 0) ? fr[idx] : 8'd0;
            end
            s.ok   = cexp(mc_ok);
            s.crc  = cexp(mc_crc);
            s.lenc = cexp(mc_len);
            s.runt = cexp(mc_runt);
            stat_q.push_back(s);
        end
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) repeat ($urandom_range(0, 2)) @(posedge rx_clk);
            if (gaps && k > 0) #1;
            drive_byte(fr[k], (stop_at == 0) && (k == len - 1), (k == mac_at));
        end
    endtask

    always @(negedge rx_clk) begin : monitor
        beat_t b;
        stat_t s;
        if (rst_int_n) begin
            if (m_axis_tvalid) begin
                chk("tvalid_needs_input", {31'd0, s_axis_tvalid}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {24'd0, m_axis_tdata}, 32'hFFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    chk("tdata", {24'd0, m_axis_tdata}, {24'd0, b.d});
                    chk("tlast", {31'd0, m_axis_tlast}, {31'd0, b.last});
                    if (b.last) chk("tuser", {31'd0, m_axis_tuser}, {31'd0, b.user});
                end
            end
            if (frame_done) begin
                if (stat_q.size() == 0) begin
                    chk("unexpected_frame_done", 32'd1, 32'd0 + 32'(stat_q.size()));
                end else begin
                    s = stat_q.pop_front();
                    chk("frame_len", {21'd0, frame_len}, {21'd0, s.len});
                    chk("frame_status", {28'd0, frame_status}, {28'd0, s.st});
                    chk("rx_fcs", rx_fcs, s.fcs);
                    chk("cnt_ok", {16'd0, cnt_ok}, {16'd0, s.ok});
                    chk("cnt_crc_err", {16'd0, cnt_crc_err}, {16'd0, s.crc});
                    chk("cnt_len_err", {16'd0, cnt_len_err}, {16'd0, s.lenc});
                    chk("cnt_runt", {16'd0, cnt_runt}, {16'd0, s.runt});
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_tvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_frame_len"}, {21'd0, frame_len}, 32'd0);
        chk({tag, "_frame_status"}, {28'd0, frame_status}, 32'd0);
        chk({tag, "_rx_fcs"}, rx_fcs, 32'd0);
        chk({tag, "_cnt_ok"}, {16'd0, cnt_ok}, 32'd0);
        chk({tag, "_cnt_crc"}, {16'd0, cnt_crc_err}, 32'd0);
        chk({tag, "_cnt_len"}, {16'd0, cnt_len_err}, 32'd0);
        chk({tag, "_cnt_runt"}, {16'd0, cnt_runt}, 32'd0);
    endtask

    initial begin : stimulus
        rst_int_n     = 1'b0;
        s_axis_tdata  = 8'd0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        repeat (3) @(negedge rx_clk);
        check_idle_outputs("reset");
        s_axis_tvalid = 1'b0;
        @(posedge rx_clk);
        #1;
        rst_int_n = 1'b1;
        repeat (2) @(posedge rx_clk);
        #1;

        send_frame(64, -1, -1, 1'b0, 0);    // good minimum frame
        send_frame(64, 10, -1, 1'b0, 0);    // corrupted payload byte
        send_frame(3, -1, -1, 1'b0, 0);     // runt
        send_frame(4, -1, -1, 1'b0, 0);     // runt at the boundary
        send_frame(5, -1, -1, 1'b0, 0);     // smallest frame that produces output
        send_frame(1519, -1, -1, 1'b0, 0);  // one byte too long
        send_frame(1518, -1, -1, 1'b0, 0);  // maximum legal frame
        send_frame(60, -1, -1, 1'b0, 0);    // too short, not a runt
        send_frame(64, -1, 5, 1'b0, 0);     // MAC error only
        send_frame(64, -1, -1, 1'b1, 0);    // back-to-back pair with gaps inside
        send_frame(64, -1, -1, 1'b1, 0);
        repeat (4) @(posedge rx_clk);
        #1;
        chk("beats_drained", 32'(exp_q.size()), 32'd0);
        chk("status_drained", 32'(stat_q.size()), 32'd0);

        // Drop a frame mid-way with an asynchronous reset.
        send_frame(64, -1, -1, 1'b0, 30);
        rst_int_n = 1'b0;
        mc_ok = 0;
        mc_crc = 0;
        mc_len = 0;
        mc_runt = 0;
        repeat (2) @(negedge rx_clk);
        check_idle_outputs("midframe_reset");
        @(posedge rx_clk);
        #1;
        rst_int_n = 1'b1;
        chk("abort_beats_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge rx_clk);
        chk("no_done_after_reset", {31'd0, frame_done}, 32'd0);
        @(posedge rx_clk);
        #1;
        send_frame(64, -1, -1, 1'b0, 0);
        repeat (4) @(posedge rx_clk);
        #1;
        chk("final_beats_drained", 32'(exp_q.size()), 32'd0);
        chk("final_status_drained", 32'(stat_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
